// File: rtl/rgb_led_pwm_pkg.sv
// Shared register map, CTRL field positions and the CTRL register layout
// for the RGB LED PWM brightness controller.
package rgb_led_pwm_pkg;

  // Byte offsets within the device window (only addr[7:2] is decoded)
  localparam logic [7:0] DUTY_BASE     = 8'h00;
  localparam logic [7:0] CTRL_OFFSET   = 8'h40;
  localparam logic [7:0] STATUS_OFFSET = 8'h44;

  // CTRL bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_LSB = 16;

  // CTRL register contents
  typedef struct packed {
    logic [15:0] prescale;
    logic        enable;
  } ctrl_t;

endpackage

// File: rtl/rgb_led_pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter and tick/wrap strobes.
// Both counters are held at zero while disabled so every enable starts a
// fresh period from count 0.
module pwm_timebase #(
  parameter int DutyWidth     = 8,
  parameter int PrescaleWidth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [PrescaleWidth-1:0] prescale,
  output logic                     tick,
  output logic                     wrap,
  output logic [DutyWidth-1:0]     period_cnt
);

  logic [PrescaleWidth-1:0] presc_cnt;

  // >= rather than == so lowering prescale below the running count
  // produces an immediate tick instead of a long overrun.
  assign tick = enable && (presc_cnt >= prescale);
  assign wrap = tick && (period_cnt == {DutyWidth{1'b1}});

  // Prescaler: counts clocks between ticks, cleared on tick or when idle
  always_ff @(posedge clk) begin
    if (rst || !enable || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // Period counter: advances once per tick, wraps naturally at 2^DutyWidth
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_led_pwm.sv
// RGB LED brightness controller: bus-programmable per-channel duty with
// period-boundary double buffering, gated by the GPO on/off bits.
//
// Bus handshake: device_req_i is a single-cycle request that is always
// accepted (no ready/stall). Exactly one cycle later device_rvalid_o pulses
// for both reads and writes; device_rdata_o carries read data in that cycle
// and is 0 in every other cycle (including write responses). A request
// sampled together with reset is dropped and produces no response.
module rgb_led_pwm
  import rgb_led_pwm_pkg::*;
#(
  parameter int          NumChannels     = 12,
  parameter int          DutyWidth       = 8,
  parameter int          PrescaleWidth   = 16,
  parameter logic [15:0] DefaultPrescale = 16'd195
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_i,
  input  logic                   device_req_i,
  input  logic [31:0]            device_addr_i,
  input  logic                   device_we_i,
  input  logic [3:0]             device_be_i,
  input  logic [31:0]            device_wdata_i,
  output logic                   device_rvalid_o,
  output logic [31:0]            device_rdata_o,
  input  logic [NumChannels-1:0] gp_en_i,
  output logic [NumChannels-1:0] pwm_o
);

  logic [DutyWidth-1:0] duty_q   [NumChannels];
  logic [DutyWidth-1:0] shadow_q [NumChannels];
  ctrl_t                ctrl_q;

  logic                 tick;
  logic                 wrap;
  logic [DutyWidth-1:0] period_cnt;

  logic [7:0]  reg_off;
  logic [5:0]  duty_idx;
  logic        duty_hit;
  logic        wr_en;
  logic [31:0] rdata_next;
  logic        unused;

  assign reg_off  = {device_addr_i[7:2], 2'b00};
  assign duty_idx = device_addr_i[7:2] - DUTY_BASE[7:2];
  assign duty_hit = duty_idx < 6'(NumChannels);
  assign wr_en    = device_req_i && device_we_i;

  // Address bits outside [7:2], be[1] and wdata[15:8] select nothing
  assign unused = ^{device_addr_i[31:8], device_addr_i[1:0], device_be_i[1],
                    device_wdata_i[15:8], tick};

  pwm_timebase #(
    .DutyWidth    (DutyWidth),
    .PrescaleWidth(PrescaleWidth)
  ) u_timebase (
    .clk       (clk_sys_i),
    .rst       (rst_sys_i),
    .enable    (ctrl_q.enable),
    .prescale  (ctrl_q.prescale),
    .tick      (tick),
    .wrap      (wrap),
    .period_cnt(period_cnt)
  );

  // DUTY registers: low byte only, written when be[0] is set
  always_ff @(posedge clk_sys_i) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (rst_sys_i) begin
        duty_q[c] <= '0;
      end else if (wr_en && duty_hit && device_be_i[0] && (duty_idx == 6'(c))) begin
        duty_q[c] <= device_wdata_i[DutyWidth-1:0];
      end
    end
  end

  // Shadow duty: follows DUTY while idle, otherwise reloads only at wrap so
  // a running period never sees a half-applied update.
  always_ff @(posedge clk_sys_i) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (rst_sys_i) begin
        shadow_q[c] <= '0;
      end else if (!ctrl_q.enable || wrap) begin
        shadow_q[c] <= duty_q[c];
      end
    end
  end

  // CTRL register: enable on byte 0, prescale on bytes 2 and 3
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      ctrl_q <= '{prescale: DefaultPrescale, enable: 1'b0};
    end else if (wr_en && (reg_off == CTRL_OFFSET)) begin
      if (device_be_i[0]) ctrl_q.enable         <= device_wdata_i[CTRL_EN_BIT];
      if (device_be_i[2]) ctrl_q.prescale[7:0]  <= device_wdata_i[CTRL_PRESC_LSB +: 8];
      if (device_be_i[3]) ctrl_q.prescale[15:8] <= device_wdata_i[CTRL_PRESC_LSB+8 +: 8];
    end
  end

  // Read mux; unmapped offsets read as zero
  always_comb begin
    rdata_next = '0;
    if (duty_hit) begin
      for (int c = 0; c < NumChannels; c++) begin
        if (duty_idx == 6'(c)) rdata_next[DutyWidth-1:0] = duty_q[c];
      end
    end else if (reg_off == CTRL_OFFSET) begin
      rdata_next[CTRL_EN_BIT]             = ctrl_q.enable;
      rdata_next[CTRL_PRESC_LSB +: 16]    = ctrl_q.prescale;
    end else if (reg_off == STATUS_OFFSET) begin
      rdata_next[DutyWidth-1:0]           = period_cnt;
    end
  end

  // Bus response: rvalid one cycle after every request, data only for reads
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= (device_req_i && !device_we_i) ? rdata_next : '0;
    end
  end

  // Per-channel comparators, registered onto the pins
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      pwm_o <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        pwm_o[c] <= ctrl_q.enable & gp_en_i[c] & (period_cnt < shadow_q[c]);
      end
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Bench for rgb_led_pwm: bus reads are scoreboarded through exp_q, PWM
// behaviour is checked by counting high/low cycles per period, with cycle
// numbering taken from the edge at which the enabling CTRL write lands.
module tb_rgb_led_pwm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic [11:0] gp_en = '0;
  logic [11:0] pwm;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard state: one kind entry per request (1 = read), exp data per read
  logic [31:0] exp_q[$];
  logic        kind_q[$];
  logic        sb_kind;
  logic [31:0] sb_exp;

  rgb_led_pwm dut (
    .clk_sys_i      (clk),
    .rst_sys_i      (rst),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .gp_en_i        (gp_en),
    .pwm_o          (pwm)
  );

  // Clock and run-time bound
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: consumes one response per rvalid, compares read data
  always @(negedge clk) begin
    if (rvalid) begin
      if (kind_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_rvalid: got rvalid=1 with no request outstanding");
      end else begin
        sb_kind = kind_q.pop_front();
        if (sb_kind) begin
          sb_exp = exp_q.pop_front();
          vectors++;
          if (rdata !== sb_exp) begin
            miscompares++;
            $display("FAIL read_data: got %08h expected %08h", rdata, sb_exp);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    kind_q.push_back(1'b0);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
    kind_q.push_back(1'b1);
    exp_q.push_back(exp);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (pwm !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_pwm: got %03h expected 000", pwm);
    end
    vectors++;
    if (rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rvalid: got %0b expected 0", rvalid);
    end
    bus_read(32'h40, 32'h00C3_0000);
    bus_read(32'h14, 32'h0);
    bus_read(32'h44, 32'h0);
  endtask

  task automatic test_ctrl_be();
    bus_write(32'h40, 32'hFFFF_0001, 4'b0001);
    bus_read(32'h40, 32'h00C3_0001);
    bus_write(32'h40, 32'h0012_0000, 4'b0100);
    bus_read(32'h40, 32'h0012_0001);
    bus_read(32'h7C, 32'h0);
    bus_write(32'h7C, 32'hFFFF_FFFF, 4'hF);
    bus_read(32'h40, 32'h0012_0001);
    bus_read(32'h00, 32'h0);
    bus_read(32'h2C, 32'h0);
    bus_write(32'h04, 32'hFFFF_FFFF, 4'b1110);
    bus_read(32'h04, 32'h0);
    bus_write(32'h04, 32'hABCD_1234, 4'hF);
    bus_read(32'h04, 32'h34);
    bus_write(32'h04, 32'h0, 4'b0001);
    bus_write(32'h40, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h14; wdata = 32'h5A; be = 4'b0001;
    kind_q.push_back(1'b0);
    @(negedge clk);
    we = 1'b0;
    kind_q.push_back(1'b1);
    exp_q.push_back(32'h5A);
    @(negedge clk);
    req = 1'b0;
    bus_write(32'h14, 32'h0, 4'b0001);
  endtask

  task automatic test_duty_quarter();
    int hi_p1, hi_p2, others;
    hi_p1 = 0; hi_p2 = 0; others = 0;
    bus_write(32'h00, 32'h40, 4'b0001);
    gp_en = 12'hFFF;
    bus_write(32'h40, 32'h0000_0001, 4'hF);
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      if (k <= 256) hi_p1 += int'(pwm[0]);
      else          hi_p2 += int'(pwm[0]);
      if (pwm[11:1] != 11'h0) others++;
    end
    vectors++;
    if (hi_p1 !== 64) begin
      miscompares++;
      $display("FAIL quarter_p1: got %0d high cycles expected 64", hi_p1);
    end
    vectors++;
    if (hi_p2 !== 64) begin
      miscompares++;
      $display("FAIL quarter_p2: got %0d high cycles expected 64", hi_p2);
    end
    vectors++;
    if (others !== 0) begin
      miscompares++;
      $display("FAIL quarter_others: got %0d cycles with ch1..11 high expected 0", others);
    end
  endtask

  task automatic test_full_duty();
    int lo_p1, lo_p2, hi0;
    lo_p1 = 0; lo_p2 = 0; hi0 = 0;
    bus_write(32'h40, 32'h0, 4'hF);
    bus_write(32'h0C, 32'hFF, 4'b0001);
    bus_write(32'h40, 32'h0001_0001, 4'hF);
    for (int k = 1; k <= 1024; k++) begin
      @(negedge clk);
      if (k <= 512) begin
        lo_p1 += int'(!pwm[3]);
        hi0   += int'(pwm[0]);
      end else begin
        lo_p2 += int'(!pwm[3]);
      end
    end
    vectors++;
    if (lo_p1 !== 2) begin
      miscompares++;
      $display("FAIL full_duty_p1: got %0d low cycles expected 2", lo_p1);
    end
    vectors++;
    if (lo_p2 !== 2) begin
      miscompares++;
      $display("FAIL full_duty_p2: got %0d low cycles expected 2", lo_p2);
    end
    vectors++;
    if (hi0 !== 128) begin
      miscompares++;
      $display("FAIL presc1_ch0: got %0d high cycles expected 128", hi0);
    end
    gp_en[3] = 1'b0;
    @(negedge clk);
    vectors++;
    if (pwm[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL gp_en_gate: got %0b expected 0", pwm[3]);
    end
    gp_en[3] = 1'b1;
  endtask

  task automatic test_shadow_mid();
    int hi_p1, hi_p2;
    hi_p1 = 0; hi_p2 = 0;
    bus_write(32'h40, 32'h0, 4'hF);
    bus_write(32'h08, 32'h10, 4'b0001);
    bus_write(32'h40, 32'h0000_0001, 4'hF);
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      if (k <= 256) hi_p1 += int'(pwm[2]);
      else          hi_p2 += int'(pwm[2]);
      if (k == 99) begin
        req = 1'b1; we = 1'b1; addr = 32'h08; wdata = 32'h80; be = 4'b0001;
        kind_q.push_back(1'b0);
      end
      if (k == 100) begin
        req = 1'b0; we = 1'b0;
      end
    end
    vectors++;
    if (hi_p1 !== 16) begin
      miscompares++;
      $display("FAIL shadow_mid_p1: got %0d high cycles expected 16", hi_p1);
    end
    vectors++;
    if (hi_p2 !== 128) begin
      miscompares++;
      $display("FAIL shadow_mid_p2: got %0d high cycles expected 128", hi_p2);
    end
  endtask

  task automatic test_shadow_wrap();
    int hi_p1, hi_p2, hi_p3;
    hi_p1 = 0; hi_p2 = 0; hi_p3 = 0;
    bus_write(32'h40, 32'h0, 4'hF);
    bus_write(32'h08, 32'h10, 4'b0001);
    bus_write(32'h40, 32'h0000_0001, 4'hF);
    for (int k = 1; k <= 768; k++) begin
      @(negedge clk);
      if (k <= 256)      hi_p1 += int'(pwm[2]);
      else if (k <= 512) hi_p2 += int'(pwm[2]);
      else               hi_p3 += int'(pwm[2]);
      // Lands on the edge where the period counter wraps 255 -> 0
      if (k == 255) begin
        req = 1'b1; we = 1'b1; addr = 32'h08; wdata = 32'h80; be = 4'b0001;
        kind_q.push_back(1'b0);
      end
      if (k == 256) begin
        req = 1'b0; we = 1'b0;
      end
    end
    vectors++;
    if (hi_p1 !== 16) begin
      miscompares++;
      $display("FAIL shadow_wrap_p1: got %0d high cycles expected 16", hi_p1);
    end
    vectors++;
    if (hi_p2 !== 16) begin
      miscompares++;
      $display("FAIL shadow_wrap_p2: got %0d high cycles expected 16", hi_p2);
    end
    vectors++;
    if (hi_p3 !== 128) begin
      miscompares++;
      $display("FAIL shadow_wrap_p3: got %0d high cycles expected 128", hi_p3);
    end
  endtask

  task automatic test_reset_mid();
    repeat (37) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b1; we = 1'b0; addr = 32'h40;
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    vectors++;
    if (pwm !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_mid_pwm: got %03h expected 000", pwm);
    end
    vectors++;
    if (rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_rvalid: got %0b expected 0", rvalid);
    end
    bus_read(32'h44, 32'h0);
    for (int c = 0; c < 12; c++) begin
      bus_read(32'(4 * c), 32'h0);
    end
    bus_read(32'h40, 32'h00C3_0000);
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_ctrl_be();
    test_back_to_back();
    test_duty_quarter();
    test_full_duty();
    test_shadow_mid();
    test_shadow_wrap();
    test_reset_mid();
    repeat (3) @(negedge clk);
    vectors++;
    if ((exp_q.size() + kind_q.size()) !== 0) begin
      miscompares++;
      $display("FAIL pending_responses: got %0d outstanding expected 0",
               exp_q.size() + kind_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
